serial_parallel: RTL and testbench
==================================

# serial_parallel

Receive end of the serial PHY link: deserializes the MSB-first bit stream produced by the parallel-to-serial transmitter back into 8-bit words. Acquires byte alignment from the idle symbol (0xBC, sent by the transmitter whenever its `valid_in` is low) and asserts `active` after a run of aligned idle symbols. Once active, presents each non-idle byte on `Data_out` with `valid_out` for one byte period. Sits between the serial channel and the parallel-side logic, in the `clk_32f` domain.

## Interface
- `IDLE_SYM`, default 8'hBC: idle/comma symbol used for alignment and as "no data".
- `LOCK_COUNT`, default 4: consecutive aligned `IDLE_SYM` bytes required before `active` rises. Legal range is 1–15.

- `clk_32f`  in  1  bit clock; one serial bit per rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on rising `clk_32f`.
- `Data_in`  in  1  serial bit, MSB of each byte first.
- `Data_out`  out  8  recovered byte.
- `valid_out`  out  1  high while `Data_out` carries a non-idle byte.
- `active`  out  1  link aligned and locked.

## Operation
- **Shift register.** Every edge, `sr <= {sr[6:0], Data_in}`.
- **Window.** The combinational window is `w = {sr[6:0], Data_in}`; it is the byte completed at the current edge.
- **Byte boundary.** 3-bit `bit_cnt` increments mod 8 when aligned. A boundary is the edge at which `bit_cnt == 7`.
- **States.** The FSM has three states: `SEARCH`, `SYNC`, `ACTIVE`.
- **SEARCH.** Bit-wise sliding compare, every edge.
  - If `w == IDLE_SYM`: set `bit_cnt <= 0` and `bc_cnt <= 1`.
  - Then go to `ACTIVE` if `LOCK_COUNT == 1`, else to `SYNC`.
- **SYNC.** Compare only at boundaries.
  - `w == IDLE_SYM`: `bc_cnt++`. When `bc_cnt` reaches `LOCK_COUNT`, go to `ACTIVE`.
  - Any other byte: `bc_cnt <= 0`, go to `SEARCH`; sliding search resumes on the next edge.
  - `valid_out` stays 0 and `Data_out` is not updated in this state.
- **ACTIVE.** At each boundary:
  - `w != IDLE_SYM`: `Data_out <= w`, `valid_out <= 1`.
  - `w == IDLE_SYM`: `valid_out <= 0`, `Data_out` holds its last value.
- **Lock retention.** `active` stays 1 until reset; there is no loss-of-lock detection in this block.
- **Counter width.** `bc_cnt` is 4 bits and saturates at `LOCK_COUNT`. It never wraps.

## Timing
- **Reset values** (while `reset == 0` at an edge):
  - `Data_out = 8'h00`, `valid_out = 0`, `active = 0`.
  - `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`, state = `SEARCH`.
- **Reset precedence.** Reset overrides everything, including mid-byte and in `ACTIVE`. After reset is released, alignment restarts from `SEARCH`.
- **Latency.** Outputs are registered and update at the boundary edge that samples the byte's LSB. They become visible after that edge and hold for 8 cycles, until the next boundary.
- **`active` timing.** `active` rises at the edge that samples the LSB of the `LOCK_COUNT`-th consecutive aligned idle symbol.
- **First data byte.** The first non-idle byte after lock sets `valid_out` at the edge sampling its LSB, i.e. 8 cycles after `active` rose if sent back-to-back.
- **Idle gap.** An idle byte in `ACTIVE` drops `valid_out` exactly at its boundary edge. There is no partial-period valid.
- **Back-to-back data.** `Data_out` changes every 8 cycles with `valid_out` held at 1 continuously.
- **Same-edge match in SEARCH.** If a sliding match and a boundary coincide, the match restarts `bit_cnt` at 0.
- **Boundary of the first SYNC byte.** Following the first match, the next boundary is 8 edges after the matching edge.

## Test plan
- **Reset.** Hold `reset = 0` for 5 cycles while driving random bits → `Data_out = 00`, `valid_out = 0`, `active = 0` throughout.
- **Aligned lock and data.** Release reset, then send BC×4 aligned, then FF, EE, AA, each MSB first.
  - `active = 1` from the 32nd bit edge onward.
  - `Data_out` = FF, EE, AA in successive 8-cycle windows, with `valid_out = 1` continuously.
- **Idle gap.** After AA, send BC, then CC.
  - During the BC period: `valid_out = 0` and `Data_out` holds AA.
  - During the CC period: `Data_out = CC`, `valid_out = 1`.
- **Misaligned stream.** Prefix the stream with 3 junk bits (101), then BC×4, then 5A → lock is achieved at the 4th BC and `Data_out = 5A`; no spurious `valid_out` during the junk bits.
- **Broken sync.** Send BC, BC, 3C, then BC×4, then 81.
  - `active` stays 0 until the 4th BC of the second run.
  - `Data_out = 81` with `valid_out = 1` afterward.
- **Reset mid-operation.** Assert `reset` for 2 cycles in the middle of a data byte in `ACTIVE`.
  - All outputs clear at the next edge.
  - After release, 4 new BCs are required before `active` returns to 1.

Source files
------------

// File: rtl/serial_parallel_if.sv
// Serial link bundle: one serial bit in, recovered byte with valid and lock status out.
// Latency: none; this is wiring only.
// Backpressure: none; the serial channel cannot be stalled, so there is no ready signal.
interface serial_parallel_if;
  logic       Data_in;
  logic [7:0] Data_out;
  logic       valid_out;
  logic       active;

  // Side that drives the serial line and consumes the recovered bytes
  modport master (
    output Data_in,
    input  Data_out,
    input  valid_out,
    input  active
  );

  // Deserializer side
  modport slave (
    input  Data_in,
    output Data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_parallel.sv
// Deserializer: MSB-first serial bits to bytes, aligned and locked on the idle symbol.
// Latency: outputs register at the edge sampling a byte's LSB and hold for 8 bit clocks.
// Backpressure: none; one byte every 8 cycles, and idle bytes leave valid_out low.
module serial_parallel #(
  parameter logic [7:0]  IDLE_SYM   = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic           clk_32f,
  input  logic           reset,
  serial_parallel_if.slave link
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  // Only the 7 most recent bits are kept; the 8th bit of the window is the live input.
  logic [6:0] sr_q,        sr_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [3:0] bc_cnt_q,    bc_cnt_d;
  state_t     state_q,     state_d;
  logic [7:0] data_out_q,  data_out_d;
  logic       valid_out_q, valid_out_d;

  logic [7:0] w;
  logic       boundary;
  logic       idle_hit;
  logic [3:0] bc_cnt_inc;

  // Byte window completed at this edge, and the boundary / idle-match qualifiers
  always_comb begin
    w          = {sr_q, link.Data_in};
    boundary   = (bit_cnt_q == 3'd7);
    idle_hit   = (w == IDLE_SYM);
    bc_cnt_inc = 4'(bc_cnt_q + 4'd1);
  end

  // Next-state logic: sliding search, idle-run counting, then byte capture once locked
  always_comb begin
    sr_d        = w[6:0];
    bit_cnt_d   = bit_cnt_q;
    bc_cnt_d    = bc_cnt_q;
    state_d     = state_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;

    unique case (state_q)
      SEARCH: begin
        // Compare at every bit position; a hit fixes the byte phase at this edge,
        // even when it happens to coincide with a stale boundary.
        if (idle_hit) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = (LOCK_CNT == 4'd1) ? ACTIVE : SYNC;
        end
      end

      SYNC: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (idle_hit) begin
            if (bc_cnt_inc >= LOCK_CNT) begin
              bc_cnt_d = LOCK_CNT;
              state_d  = ACTIVE;
            end else begin
              bc_cnt_d = bc_cnt_inc;
            end
          end else begin
            // Wrong phase or a corrupted idle: forget the run and slide again
            bc_cnt_d  = 4'd0;
            bit_cnt_d = 3'd0;
            state_d   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (idle_hit) begin
            valid_out_d = 1'b0;
          end else begin
            data_out_d  = w;
            valid_out_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      bc_cnt_q    <= '0;
      state_q     <= SEARCH;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      bc_cnt_q    <= bc_cnt_d;
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign link.Data_out  = data_out_q;
  assign link.valid_out = valid_out_q;
  // Lock is held for as long as the FSM stays in ACTIVE, which only reset leaves
  assign link.active    = (state_q == ACTIVE);

endmodule

// File: tb/tb_serial_parallel.sv
// Bench for serial_parallel: directed scenarios plus random streams against a bit-history model.
// Latency: outputs are compared half a clock after each edge that samples a serial bit.
// Backpressure: none; the serial line is driven one bit per clock.
module tb_serial_parallel;

  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         LC   = 4;

  logic clk_32f = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  serial_parallel_if link();

  serial_parallel #(.IDLE_SYM(IDLE), .LOCK_COUNT(LC)) dut (
    .clk_32f (clk_32f),
    .reset   (rst_n),
    .link    (link)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: the full bit history since reset, plus the edge index at
  // which alignment was found (-1 while searching).
  bit         hist[$];
  int         anchor;
  int         idles;
  bit         m_active;
  logic [7:0] m_dout;
  bit         m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] window_at(input int n);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) begin
      int idx = n - 7 + i;
      v = {v[6:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    return v;
  endfunction

  task automatic model_edge(input bit rst, input bit b);
    int n;
    logic [7:0] wv;
    if (!rst) begin
      hist.delete();
      anchor   = -1;
      idles    = 0;
      m_active = 0;
      m_dout   = 8'h00;
      m_vld    = 0;
      return;
    end
    hist.push_back(b);
    n  = hist.size() - 1;
    wv = window_at(n);
    if (anchor < 0) begin
      if (wv == IDLE) begin
        anchor = n;
        idles  = 1;
        if (LC == 1) m_active = 1;
      end
    end else if (((n - anchor) % 8) == 0) begin
      if (!m_active) begin
        if (wv == IDLE) begin
          idles++;
          if (idles >= LC) m_active = 1;
        end else begin
          anchor = -1;
          idles  = 0;
        end
      end else if (wv != IDLE) begin
        m_dout = wv;
        m_vld  = 1;
      end else begin
        m_vld = 0;
      end
    end
  endtask

  // One bit clock: drive at the falling edge, let the rising edge sample, check at the next falling edge
  task automatic step(input bit rst, input bit b);
    rst_n        = rst;
    link.Data_in = b;
    model_edge(rst, b);
    @(posedge clk_32f);
    @(negedge clk_32f);
    chk("data_out",  {24'h0, link.Data_out}, {24'h0, m_dout});
    chk("valid_out", {31'h0, link.valid_out}, {31'h0, m_vld});
    chk("active",    {31'h0, link.active},    {31'h0, m_active});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b1, v[i]);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [7:0] rb;
    rst_n        = 1'b0;
    link.Data_in = 1'b0;
    model_edge(1'b0, 1'b0);
    @(negedge clk_32f);

    // Reset held with random serial activity
    do_reset(5);
    chk("reset_dout",   {24'h0, link.Data_out}, 32'h0);
    chk("reset_active", {31'h0, link.active},   32'h0);

    // Aligned lock followed by back-to-back data
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    chk("aligned_pre_lock", {31'h0, link.active}, 32'h0);
    send_byte(IDLE);
    chk("aligned_lock", {31'h0, link.active}, 32'h1);
    send_byte(8'hFF);
    chk("aligned_ff", {24'h0, link.Data_out}, 32'hFF);
    send_byte(8'hEE);
    chk("aligned_ee", {24'h0, link.Data_out}, 32'hEE);
    send_byte(8'hAA);
    chk("aligned_aa", {24'h0, link.Data_out}, 32'hAA);
    chk("aligned_vld", {31'h0, link.valid_out}, 32'h1);

    // Idle gap between data bytes
    send_byte(IDLE);
    chk("gap_vld",  {31'h0, link.valid_out}, 32'h0);
    chk("gap_hold", {24'h0, link.Data_out},  32'hAA);
    send_byte(8'hCC);
    chk("gap_cc",     {24'h0, link.Data_out},  32'hCC);
    chk("gap_cc_vld", {31'h0, link.valid_out}, 32'h1);

    // Misaligned stream with 3 junk bits up front
    do_reset(2);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(IDLE);
    chk("misalign_lock", {31'h0, link.active}, 32'h1);
    send_byte(8'h5A);
    chk("misalign_5a",  {24'h0, link.Data_out},  32'h5A);
    chk("misalign_vld", {31'h0, link.valid_out}, 32'h1);

    // Broken idle run restarts the lock count
    do_reset(2);
    send_byte(IDLE); send_byte(IDLE); send_byte(8'h3C);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    chk("broken_no_lock", {31'h0, link.active}, 32'h0);
    send_byte(IDLE);
    chk("broken_lock", {31'h0, link.active}, 32'h1);
    send_byte(8'h81);
    chk("broken_81",  {24'h0, link.Data_out},  32'h81);
    chk("broken_vld", {31'h0, link.valid_out}, 32'h1);

    // Reset in the middle of a data byte while locked
    rb = 8'h96;
    for (int i = 7; i >= 4; i--) step(1'b1, rb[i]);
    step(1'b0, 1'b1);
    chk("midrst_dout",   {24'h0, link.Data_out},  32'h0);
    chk("midrst_vld",    {31'h0, link.valid_out}, 32'h0);
    chk("midrst_active", {31'h0, link.active},    32'h0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    chk("midrst_relock_early", {31'h0, link.active}, 32'h0);
    send_byte(IDLE);
    chk("midrst_relock", {31'h0, link.active}, 32'h1);

    // Random streams: junk prefix, idle run, mixed data/idle traffic
    for (int r = 0; r < 12; r++) begin
      do_reset(int'($urandom_range(1, 3)));
      for (int j = 0, nj = int'($urandom_range(0, 12)); j < nj; j++)
        step(1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        send_byte(IDLE);
        send_byte(8'($urandom));
      end
      for (int j = 0; j < LC; j++) send_byte(IDLE);
      for (int j = 0; j < 16; j++) begin
        if ($urandom_range(0, 3) == 0) send_byte(IDLE);
        else                           send_byte(8'($urandom));
      end
      for (int j = 0, nj = int'($urandom_range(0, 7)); j < nj; j++)
        step(1'b1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
